// File: rtl/opfetch_pkg.sv
// Shared types and constants for the operand fetch stage: FSM states,
// opcodes that need an rs2 operand, and default widths.
package opfetch_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int RADDR_W_DEFAULT = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        RS2,
        CAP,
        VALID
    } state_t;

    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/opfetch_opnd_reg.sv
// One operand capture register: x0 zeroing, writeback-over-regfile priority
// on capture, and writeback snooping while the operand is held.
module opfetch_opnd_reg
    import opfetch_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RADDR_W = RADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               capture_en,
    input  logic               snoop_en,
    input  logic [RADDR_W-1:0] rs,
    input  logic [XLEN-1:0]    rf_dout,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    data
);

    logic rs_is_zero;
    logic wb_hit;

    assign rs_is_zero = (rs == '0);
    assign wb_hit     = wb_we && !rs_is_zero && (wb_addr == rs);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            data <= '0;
        end else if (capture_en) begin
            if (rs_is_zero)  data <= '0;
            else if (wb_hit) data <= wb_data;
            else             data <= rf_dout;
        end else if (snoop_en && wb_hit) begin
            data <= wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: sequences rs1/rs2 reads through a single regfile read
// port and hands a complete operand bundle to EX. Optional macro
// OPFETCH_SKIP_RS2_EN lets opcodes without an rs2 operand skip the second read.
module operand_fetch
    import opfetch_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int RADDR_W = RADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic [RADDR_W-1:0] rf_read_addr,
    input  logic [XLEN-1:0]    rf_dout,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data
);

    state_t             state;
    logic [31:0]        instr_q;
    logic [XLEN-1:0]    pc_q;
    logic               out_valid_q;
    logic [RADDR_W-1:0] held_rs1;
    logic [RADDR_W-1:0] held_rs2;
    logic [RADDR_W-1:0] rs2_sel;
    logic               skip_rs2;
    logic               accept;

    assign held_rs1 = instr_q[15 +: RADDR_W];
    assign held_rs2 = instr_q[20 +: RADDR_W];

`ifdef OPFETCH_SKIP_RS2_EN
    assign skip_rs2 = !reads_rs2(instr_q[6:0]);
`else
    assign skip_rs2 = 1'b0;
`endif

    // A skipped rs2 is presented as x0 so it captures zero and never snoops.
    assign rs2_sel = skip_rs2 ? '0 : held_rs2;

    // NOTE: every combinational output gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        in_ready     = 1'b0;
        rf_read_addr = held_rs2;
        case (state)
            IDLE: begin
                in_ready     = !flush;
                rf_read_addr = in_instr[15 +: RADDR_W];
            end
            VALID: begin
                in_ready     = out_ready && !flush;
                rf_read_addr = in_instr[15 +: RADDR_W];
            end
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= in_instr;
                        pc_q    <= in_pc;
                        state   <= RS2;
                    end
                end
                RS2: begin
                    if (skip_rs2) begin
                        state       <= VALID;
                        out_valid_q <= 1'b1;
                    end else begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    state       <= VALID;
                    out_valid_q <= 1'b1;
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            instr_q <= in_instr;
                            pc_q    <= in_pc;
                            state   <= RS2;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

    opfetch_opnd_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs1 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .capture_en (state == RS2),
        .snoop_en   ((state == CAP) || (state == VALID)),
        .rs         (held_rs1),
        .rf_dout    (rf_dout),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .data       (out_rs1_data)
    );

    opfetch_opnd_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_rs2 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .capture_en ((state == CAP) || ((state == RS2) && skip_rs2)),
        .snoop_en   (state == VALID),
        .rs         (rs2_sel),
        .rf_dout    (rf_dout),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .data       (out_rs2_data)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: regfile model, abstract timing and
// architectural-register model, per-cycle compare plus directed literal checks.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_dout;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD_X7  = 32'h006283B3;  // add x7,x5,x6
    localparam logic [31:0] ADD_X0  = 32'h000000B3;  // add x1,x0,x0
    localparam logic [31:0] ADD_X8  = 32'h00628433;  // add x8,x5,x6
    localparam logic [31:0] ADD_X9  = 32'h001304B3;  // add x9,x6,x1
    localparam logic [31:0] BEQ_15  = 32'h00508063;  // beq x1,x5,0
    localparam logic [31:0] ADDI_X5 = 32'h00128293;  // addi x5,x5,1
    localparam logic [31:0] SW_X6   = 32'h0062A023;  // sw x6,0(x5)

    operand_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_read_addr (rf_read_addr),
        .rf_dout      (rf_dout),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data)
    );

    always #5 clk = ~clk;

    // Regfile: one registered read port, write-through forwarding, x0 not hardwired.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            rf_dout <= '0;
        end else begin
            if (wb_we) regs[wb_addr] <= wb_data;
            rf_dout <= (wb_we && wb_addr == rf_read_addr) ? wb_data : regs[rf_read_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [31:0] ins);
        logic skip_en;
`ifdef OPFETCH_SKIP_RS2_EN
        skip_en = 1'b1;
`else
        skip_en = 1'b0;
`endif
        if (skip_en && ins[6:0] != 7'h33 && ins[6:0] != 7'h63 && ins[6:0] != 7'h23) return 2;
        return 3;
    endfunction

    // Model: an accepted instruction occupies the stage for lat_of() cycles,
    // then is offered until EX takes it; operands equal current register values.
    logic        m_busy, m_valid;
    int          m_cnt, m_age;
    logic [31:0] m_instr, m_pc;

    function automatic logic exp_in_ready();
        return !flush && (!m_busy || (m_valid && out_ready));
    endfunction

    function automatic logic [31:0] arch_val(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : regs[r];
    endfunction

    always @(posedge clk) begin
        logic acc;
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_age = 0;
            m_instr = '0; m_pc = '0;
        end else if (flush) begin
            m_busy = 1'b0; m_valid = 1'b0;
        end else begin
            acc = in_valid && exp_in_ready();
            if (m_valid && out_ready) begin
                m_valid = 1'b0; m_busy = 1'b0;
            end else if (m_busy && !m_valid) begin
                m_age++;
                m_cnt--;
                if (m_cnt == 0) m_valid = 1'b1;
            end
            if (acc) begin
                m_busy = 1'b1; m_valid = 1'b0;
                m_instr = in_instr; m_pc = in_pc;
                m_cnt = lat_of(in_instr) - 1;
                m_age = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready()});
            check("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (!m_busy || m_valid)
                check("cmp_rf_addr_rs1", {27'b0, rf_read_addr}, {27'b0, in_instr[19:15]});
            else if (m_age == 1)
                check("cmp_rf_addr_rs2", {27'b0, rf_read_addr}, {27'b0, m_instr[24:20]});
            if (m_valid) begin
                check("cmp_out_instr", out_instr, m_instr);
                check("cmp_out_pc", out_pc, m_pc);
                check("cmp_rs1_data", out_rs1_data, arch_val(m_instr[19:15]));
                check("cmp_rs2_data", out_rs2_data,
                      (lat_of(m_instr) == 2) ? 32'h0 : arch_val(m_instr[24:20]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic measure(input string name, input logic [31:0] ins, input int exp_lat,
                           input logic [31:0] exp_rs1, input logic [31:0] exp_rs2);
        int  lat;
        logic found;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = ins; in_pc = 32'h500;
        @(negedge clk);
        step();
        in_valid = 1'b0;
        lat = 1; found = 1'b0;
        while (!found && lat < 10) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else begin step(); lat++; end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_rs1"}, out_rs1_data, exp_rs1);
        check({name, "_rs2"}, out_rs2_data, exp_rs2);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int hs [3];
        int n;
        int k;
        logic acc;
        logic [31:0] b2b [3];

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_rs1", out_rs1_data, 32'h0);
        check("rst_rs2", out_rs2_data, 32'h0);
        step();

        wb_write(5'd0, 32'hDEAD);
        wb_write(5'd1, 32'h1234);
        wb_write(5'd5, 32'h11);
        wb_write(5'd6, 32'h22);

        // Basic add x7,x5,x6 with EX ready
        out_ready = 1'b1; in_valid = 1'b1; in_instr = ADD_X7; in_pc = 32'h100;
        @(negedge clk); check("t1_addr_T", {27'b0, rf_read_addr}, 32'd5);
        step(); in_valid = 1'b0;
        @(negedge clk); check("t1_addr_T1", {27'b0, rf_read_addr}, 32'd6);
        check("t1_valid_T1", {31'b0, out_valid}, 32'h0);
        step();
        @(negedge clk); check("t1_valid_T2", {31'b0, out_valid}, 32'h0);
        step();
        @(negedge clk);
        check("t1_valid_T3", {31'b0, out_valid}, 32'h1);
        check("t1_rs1", out_rs1_data, 32'h11);
        check("t1_rs2", out_rs2_data, 32'h22);
        check("t1_pc", out_pc, 32'h100);
        step();

        // x0 operands read as zero even though entry 0 holds 0xDEAD
        in_valid = 1'b1; in_instr = ADD_X0; in_pc = 32'h104;
        step(); in_valid = 1'b0;
        step(); step();
        @(negedge clk);
        check("t2_valid", {31'b0, out_valid}, 32'h1);
        check("t2_rs1_x0", out_rs1_data, 32'h0);
        check("t2_rs2_x0", out_rs2_data, 32'h0);
        step();

        // Writeback during rs1 capture and during a held VALID
        out_ready = 1'b0; in_valid = 1'b1; in_instr = ADD_X7; in_pc = 32'h200;
        step(); in_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h99;
        step(); wb_we = 1'b0;
        step();
        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h77;
        @(negedge clk);
        check("t3_valid", {31'b0, out_valid}, 32'h1);
        check("t3_rs1_cap_fwd", out_rs1_data, 32'h99);
        check("t3_rs2_before_snoop", out_rs2_data, 32'h22);
        step(); wb_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_hold_valid", {31'b0, out_valid}, 32'h1);
            check("t3_hold_rs1", out_rs1_data, 32'h99);
            check("t3_hold_rs2_snoop", out_rs2_data, 32'h77);
            check("t3_hold_instr", out_instr, ADD_X7);
            step();
        end
        out_ready = 1'b1;
        step();

        // Three back-to-back instructions
        b2b[0] = ADD_X8; b2b[1] = ADD_X9; b2b[2] = BEQ_15;
        n = 0; k = 0;
        in_valid = 1'b1; in_instr = b2b[0]; in_pc = 32'h300;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (out_valid && n < 3) begin hs[n] = cyc; n++; end
            acc = in_valid && in_ready;
            step();
            if (acc) k++;
            if (k < 3) begin in_instr = b2b[k]; in_pc = 32'h300 + 32'(4 * k); end
            else in_valid = 1'b0;
        end
        check("t4_handshakes", n, 3);
        if (n == 3) begin
            check("t4_first_valid", hs[0], 3);
            check("t4_gap_01", hs[1] - hs[0], 3);
            check("t4_gap_12", hs[2] - hs[1], 3);
        end

        // Flush in CAP
        in_valid = 1'b1; in_instr = ADD_X7; in_pc = 32'h400;
        step(); in_valid = 1'b0;
        step();
        flush = 1'b1;
        @(negedge clk); check("t5_flush_in_ready", {31'b0, in_ready}, 32'h0);
        step(); flush = 1'b0;
        @(negedge clk);
        check("t5_after_flush_valid", {31'b0, out_valid}, 32'h0);
        check("t5_after_flush_ready", {31'b0, in_ready}, 32'h1);
        step();
        @(negedge clk); check("t5_still_idle", {31'b0, out_valid}, 32'h0);
        step();

        // Flush together with in_valid in IDLE drops the instruction
        in_valid = 1'b1; flush = 1'b1; in_instr = ADD_X7; in_pc = 32'h404;
        @(negedge clk); check("t5_drop_in_ready", {31'b0, in_ready}, 32'h0);
        step(); in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_drop_no_valid", {31'b0, out_valid}, 32'h0);
            check("t5_drop_idle", {31'b0, in_ready}, 32'h1);
            step();
        end

        // Latency per opcode class
`ifdef OPFETCH_SKIP_RS2_EN
        measure("t6_addi", ADDI_X5, 2, 32'h99, 32'h0);
`else
        measure("t6_addi", ADDI_X5, 3, 32'h99, 32'h1234);
`endif
        measure("t6_store", SW_X6, 3, 32'h99, 32'h77);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side operand fetch stage; sits directly upstream of the single-read-port register file.
- Accepts a fetched instruction from IF and issues rs1 then rs2 reads through the one regfile read port.
- Captures the registered read data, applies writeback snooping and x0 zeroing, and presents a complete operand bundle to EX with valid/ready.

Parameters:
- XLEN, 32, data width of operands and PC.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard held or in-flight instruction.
- in_valid  in  1  IF instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- rf_read_addr  out  RADDR_W  regfile read address, combinational from state.
- rf_dout  in  XLEN  regfile data, valid one cycle after address.
- wb_we  in  1  writeback write enable (same signal that drives the regfile).
- wb_addr  in  RADDR_W  writeback address.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  EX accepts.
- out_instr  out  32  held instruction.
- out_pc  out  XLEN  held PC.
- out_rs1_data  out  XLEN  rs1 operand.
- out_rs2_data  out  XLEN  rs2 operand.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- rst: state IDLE; out_valid=0; out_instr, out_pc and both operand registers are 0. in_ready follows from state (1 in IDLE).
- Register fields: rs1=instr[19:15], rs2=instr[24:20].
- States: IDLE, RS2, CAP, VALID.
- IDLE:
  - in_ready=1; rf_read_addr=in_instr rs1.
  - On in_valid: latch instr and pc, go to RS2.
- RS2:
  - rf_read_addr=held rs2.
  - Capture rs1 from rf_dout, go to CAP.
- CAP:
  - rf_read_addr=held rs2 (don't-care).
  - Capture rs2 from rf_dout, go to VALID.
- VALID:
  - out_valid=1; in_ready=out_ready; rf_read_addr=in_instr rs1.
  - out_valid & out_ready & in_valid: accept the next instruction, go to RS2.
  - out_valid & out_ready & !in_valid: go to IDLE.
  - !out_ready: hold; all outputs stable.
- Latency and throughput:
  - Accept at cycle T gives out_valid at T+3.
  - Back-to-back throughput is one instruction per 3 cycles.
- Capture priority (rs1 in RS2, rs2 in CAP):
  - rs==0 gives 0.
  - Else wb_we && wb_addr==rs gives wb_data.
  - Else rf_dout.
- Snoop: in CAP and VALID, a captured operand with rs!=0 and wb_we && wb_addr==rs is overwritten with wb_data. The same applies to rs1 in CAP.
- flush:
  - Highest priority after rst: next state IDLE, out_valid=0.
  - in_ready=0 in the flush cycle; a simultaneous in_valid is dropped.
  - Flush in VALID with out_ready=1 loses the handoff (EX must ignore).
- Regfile writes that coincide with the read cycle are forwarded by the regfile itself; this block does not recheck them.

Optional Feature:
- Macro: OPFETCH_SKIP_RS2_EN.
- Defined:
  - Opcodes other than OP (0110011), BRANCH (1100011) and STORE (0100011) skip rs2.
  - RS2 captures rs1 and goes directly to VALID.
  - out_rs2_data=0; latency 2, throughput one per 2 cycles for those opcodes.
- Undefined: every instruction takes the full 3-cycle path.

Decomposition:
- Package opfetch_pkg:
  - state enum (IDLE, RS2, CAP, VALID);
  - opcode localparams OPC_OP, OPC_BRANCH, OPC_STORE;
  - XLEN and RADDR_W defaults.
- Sub-module opfetch_opnd_reg, instantiated twice (rs1, rs2). It is a capture register with x0 zeroing, capture-priority mux and writeback snoop. Inputs: capture enable, rs, rf_dout, wb_*, flush/rst.

Test Plan:
- Regfile preloaded x5=0x11, x6=0x22; accept add x7,x5,x6 at T with out_ready=1 -> rf_read_addr 5 at T, 6 at T+1; out_valid at T+3 with rs1=0x11, rs2=0x22.
- Instruction with rs1=x0, rs2=x0, regfile entry 0 forced to 0xDEAD -> both operands 0.
- Write x5=0x99 during the RS2 cycle (rs1 capture) and x6=0x77 during VALID with out_ready=0 -> outputs 0x99 and 0x77 respectively.
- Three back-to-back instructions with out_ready held 1 -> out_valid pulses every 3 cycles, no drop; out_ready=0 for 4 cycles -> bundle held stable.
- flush asserted in CAP -> next cycle IDLE, out_valid stays 0, in_ready=1; flush together with in_valid in IDLE -> instruction not accepted.
- With OPFETCH_SKIP_RS2_EN: addi x5,x5,1 accepted at T -> out_valid at T+2, rs2=0; a store still takes T+3.
